// File: rtl/wash_payment_ctrl.sv
// Coin-credit front end for the washing machine: collects coins, charges the
// wash price, drives coin_in/double_wash for a fixed hold time, then refunds change.
module wash_payment_ctrl #(
  parameter int unsigned CREDIT_W     = 8,
  parameter int unsigned PRICE_SINGLE = 4,
  parameter int unsigned PRICE_DOUBLE = 6,
  parameter int unsigned MAX_CREDIT   = 20,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned HOLD_CYC     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                start_req,
  input  logic                double_sel,
  input  logic                cancel_req,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                refund_pulse,
  output logic                busy
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned HLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [HLD_W-1:0]    HLD_LAST  = HLD_W'(HOLD_CYC - 1);
  localparam logic [CREDIT_W:0]   MAX_U     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_S_U = (CREDIT_W + 1)'(PRICE_SINGLE);
  localparam logic [CREDIT_W:0]   PRICE_D_U = (CREDIT_W + 1)'(PRICE_DOUBLE);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_RUN     = 3'd3,
    ST_REFUND  = 3'd4
  } state_e;

  // Coin code to unit value, one bit wider than credit so the sum never wraps.
  function automatic logic [CREDIT_W:0] coin_units(input logic [1:0] code);
    logic [CREDIT_W:0] units;
    case (code)
      2'd1:    units = (CREDIT_W + 1)'(1);
      2'd2:    units = (CREDIT_W + 1)'(2);
      2'd3:    units = (CREDIT_W + 1)'(5);
      default: units = '0;
    endcase
    return units;
  endfunction

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [HLD_W-1:0]    hold_q, hold_d;
  logic                dbl_q, dbl_d;
  logic                phase_q, phase_d;
  logic                wd_q;

  logic coin_in_q, coin_in_d;
  logic double_wash_q, double_wash_d;
  logic coin_reject_q, coin_reject_d;
  logic refund_pulse_q, refund_pulse_d;
  logic busy_q, busy_d;

  logic [CREDIT_W:0]   coin_units_s, sum_s, price_s;
  logic [CREDIT_W-1:0] credit_acc_s, launch_left_s;
  logic                open_s, accept_s, reject_s, afford_s, wd_rise_s;

  assign coin_units_s  = coin_units(coin_value);
  assign sum_s         = {1'b0, credit_q} + coin_units_s;
  assign open_s        = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign accept_s      = open_s && coin_valid && (coin_units_s != '0) && (sum_s <= MAX_U);
  assign reject_s      = coin_valid && !accept_s;
  assign credit_acc_s  = accept_s ? sum_s[CREDIT_W-1:0] : credit_q;
  assign price_s       = double_sel ? PRICE_D_U : PRICE_S_U;
  // Affordability is judged on the credit before any coin arriving this cycle.
  assign afford_s      = ({1'b0, credit_q} >= price_s);
  assign launch_left_s = credit_acc_s - price_s[CREDIT_W-1:0];
  assign wd_rise_s     = wash_done && !wd_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmr_d    = tmr_q;
    hold_d   = hold_q;
    dbl_d    = dbl_q;
    phase_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        credit_d = credit_acc_s;
        tmr_d    = '0;
        if (accept_s) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        credit_d = credit_acc_s;
        if (cancel_req) begin
          state_d = ST_REFUND;
        end else if (start_req && afford_s) begin
          state_d  = ST_LAUNCH;
          credit_d = launch_left_s;
          dbl_d    = double_sel;
          hold_d   = '0;
        end else if (start_req || accept_s) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_REFUND;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_LAUNCH: begin
        if (hold_q == HLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HLD_W'(1);
        end
      end
      ST_RUN: begin
        if (wd_rise_s) begin
          state_d = (credit_q != '0) ? ST_REFUND : ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REFUND: begin
        // phase 0 issues a pulse, phase 1 is the mandatory low gap.
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (!phase_q) begin
          credit_d = credit_q - CREDIT_W'(1);
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    coin_in_d      = (state_d == ST_LAUNCH);
    double_wash_d  = (state_d == ST_LAUNCH) && dbl_d;
    busy_d         = (state_d == ST_LAUNCH) || (state_d == ST_RUN) || (state_d == ST_REFUND);
    coin_reject_d  = reject_s;
    refund_pulse_d = (state_q == ST_REFUND) && !phase_q && (credit_q != '0);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      tmr_q    <= '0;
      hold_q   <= '0;
      dbl_q    <= 1'b0;
      phase_q  <= 1'b0;
      wd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmr_q    <= tmr_d;
      hold_q   <= hold_d;
      dbl_q    <= dbl_d;
      phase_q  <= phase_d;
      wd_q     <= wash_done;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_in_q      <= 1'b0;
      double_wash_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      refund_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      coin_in_q      <= coin_in_d;
      double_wash_q  <= double_wash_d;
      coin_reject_q  <= coin_reject_d;
      refund_pulse_q <= refund_pulse_d;
      busy_q         <= busy_d;
    end
  end

  assign coin_in      = coin_in_q;
  assign double_wash  = double_wash_q;
  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign refund_pulse = refund_pulse_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_wash_payment_ctrl.sv
// Bench for wash_payment_ctrl: directed scenarios plus random coin/start rounds,
// checked against a transaction-level credit model.
module tb_wash_payment_ctrl;

  localparam int MAXC = 20;
  localparam int HOLD = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, start_req, double_sel, cancel_req, wash_done;
  logic [1:0] coin_value;
  logic       coin_in, double_wash, coin_reject, refund_pulse, busy;
  logic [7:0] credit;

  int vectors = 0;
  int miscompares = 0;
  int mcredit = 0;

  wash_payment_ctrl dut (
    .clk(clk), .rst(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .start_req(start_req), .double_sel(double_sel), .cancel_req(cancel_req),
    .wash_done(wash_done), .coin_in(coin_in), .double_wash(double_wash),
    .credit(credit), .coin_reject(coin_reject), .refund_pulse(refund_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int units(input int code);
    case (code)
      1: return 1;
      2: return 2;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int price(input int d);
    return (d != 0) ? 6 : 4;
  endfunction

  // Coin while accepting credit: model decides acceptance by the ceiling rule.
  task automatic coin(input int code);
    int  u;
    bit  ok;
    u  = units(code);
    ok = (u != 0) && (mcredit + u <= MAXC);
    coin_valid = 1'b1;
    coin_value = code[1:0];
    cyc(1);
    coin_valid = 1'b0;
    if (ok) mcredit += u;
    check("coin_reject", coin_reject, ok ? 0 : 1);
    check("coin_credit", credit, mcredit);
  endtask

  task automatic coin_busy(input int code);
    coin_valid = 1'b1;
    coin_value = code[1:0];
    cyc(1);
    coin_valid = 1'b0;
    check("busy_coin_reject", coin_reject, 1);
    check("busy_coin_credit", credit, mcredit);
  endtask

  task automatic press_start(input int d);
    start_req  = 1'b1;
    double_sel = d[0];
    cyc(1);
    start_req = 1'b0;
  endtask

  task automatic press_cancel();
    cancel_req = 1'b1;
    cyc(1);
    cancel_req = 1'b0;
  endtask

  // Refund drain: expect exactly n pulses, two cycles apart, ending with credit 0 and idle.
  task automatic drain(input int n);
    int pulses = 0;
    int prev = 0;
    int i = 0;
    bit gap_ok = 1'b1;
    while (busy === 1'b1 && i < 200) begin
      if (refund_pulse === 1'b1) begin
        if (pulses > 0 && (i - prev) != 2) gap_ok = 1'b0;
        prev = i;
        pulses++;
      end
      cyc(1);
      i++;
    end
    check("refund_count", pulses, n);
    check("refund_spacing", gap_ok, 1);
    check("refund_idle", busy, 0);
    check("refund_credit", credit, 0);
    mcredit = 0;
  endtask

  task automatic launch(input int d);
    int hi = 0;
    bit same = 1'b1;
    press_start(d);
    mcredit -= price(d);
    check("launch_credit", credit, mcredit);
    while (coin_in === 1'b1 && hi < 100) begin
      if (double_wash !== d[0]) same = 1'b0;
      hi++;
      cyc(1);
    end
    check("hold_len", hi, HOLD);
    check("dw_tracks_coin_in", same, 1);
    check("dw_released", double_wash, 0);
    check("run_busy", busy, 1);
  endtask

  task automatic finish_wash();
    wash_done = 1'b1;
    cyc(1);
    wash_done = 1'b0;
    drain(mcredit);
  endtask

  task automatic run_wash(input int d);
    if (mcredit >= price(d)) begin
      launch(d);
      finish_wash();
    end else begin
      press_start(d);
      check("short_start_busy", busy, 0);
      check("short_start_credit", credit, mcredit);
      press_cancel();
      drain(mcredit);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    coin_valid = 1'b0; coin_value = 2'd0; start_req = 1'b0;
    double_sel = 1'b0; cancel_req = 1'b0; wash_done = 1'b0;
    #23;
    check("rst_credit", credit, 0);
    check("rst_coin_in", coin_in, 0);
    check("rst_double", double_wash, 0);
    check("rst_busy", busy, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_refund", refund_pulse, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(1);

    // single wash, exact credit
    coin(2); coin(2);
    run_wash(0);
    // double wash with one unit change
    coin(3); coin(2);
    run_wash(1);

    // ceiling behaviour
    coin(3); coin(3); coin(3); coin(2); coin(1);
    check("credit_18", credit, 18);
    coin(3); coin(0); coin(2); coin(1);
    check("credit_ceiling", credit, 20);
    press_cancel();
    drain(20);

    // insufficient start, then cancel beats start
    coin(2); coin(1);
    press_start(0);
    check("ignored_start_busy", busy, 0);
    check("ignored_start_credit", credit, 3);
    coin(2);
    cancel_req = 1'b1; start_req = 1'b1; double_sel = 1'b0;
    cyc(1);
    cancel_req = 1'b0; start_req = 1'b0;
    check("cancel_prio_coin_in", coin_in, 0);
    drain(5);

    // inactivity timeout
    coin(2);
    cyc(999);
    check("timeout_not_yet", busy, 0);
    cyc(1);
    check("timeout_fired", busy, 1);
    drain(2);
    coin(2);
    cyc(999);
    coin(1);
    check("late_coin_busy", busy, 0);
    cyc(999);
    check("restart_not_yet", busy, 0);
    cyc(1);
    check("restart_fired", busy, 1);
    drain(3);

    // wash_done already high when the wash starts
    wash_done = 1'b1;
    cyc(2);
    coin(2); coin(2);
    launch(0);
    coin_busy(1);
    cyc(10);
    check("stale_done_busy", busy, 1);
    wash_done = 1'b0;
    cyc(3);
    check("done_low_busy", busy, 1);
    wash_done = 1'b1;
    cyc(1);
    wash_done = 1'b0;
    drain(0);

    // random rounds against the credit model
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) coin($urandom_range(0, 3));
      run_wash($urandom_range(0, 1));
    end

    // asynchronous reset in the middle of a launch
    coin(3); coin(2);
    press_start(1);
    cyc(5);
    check("pre_rst_coin_in", coin_in, 1);
    check("pre_rst_double", double_wash, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_coin_in", coin_in, 0);
    check("async_rst_double", double_wash, 0);
    check("async_rst_credit", credit, 0);
    check("async_rst_busy", busy, 0);
    mcredit = 0;
    @(negedge clk) rst_n = 1'b1;
    cyc(3);
    check("post_rst_busy", busy, 0);
    check("post_rst_credit", credit, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
